// File: rtl/fp_template_store.sv
// fp_template_store: holds N_SLOTS fingerprint templates of DEPTH rows x ROW_W bits.
// A framed valid/ready write stream fills one slot at a time. The video port
// reads one row and the search port reads two rows, both concurrently with the
// writer. A slot is readable only once a complete template has been committed
// and while it is not being rewritten.
//
// Optional feature macro: FP_STORE_CSUM_EN adds a 16-bit XOR checksum of each
// committed template (wr_csum / wr_csum_valid).
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   wr_valid/wr_ready            write beat handshake
//   wr_first/wr_last/wr_slot     template framing and target slot
//   wr_data                      row data
//   wr_busy, wr_err              writer not idle, framing-error pulse
//   clr_en/clr_slot              invalidate a slot
//   slot_valid                   per-slot committed flags
//   vid_*                        one-row read port, 1-cycle latency
//   srch_*                       two-row read port {row_b,row_a}, 1-cycle latency
//   wr_csum/wr_csum_valid        checksum of committed template (macro only)
module fp_template_store #(
    parameter int unsigned ROW_W   = 256,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned N_SLOTS = 4,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned SW = $clog2(N_SLOTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic                 wr_first,
    input  logic                 wr_last,
    input  logic [SW-1:0]        wr_slot,
    input  logic [ROW_W-1:0]     wr_data,
    output logic                 wr_busy,
    output logic                 wr_err,
    input  logic                 clr_en,
    input  logic [SW-1:0]        clr_slot,
    output logic [N_SLOTS-1:0]   slot_valid,
    input  logic                 vid_rd_en,
    input  logic [SW-1:0]        vid_slot,
    input  logic [AW-1:0]        vid_add,
    output logic [ROW_W-1:0]     vid_q,
    output logic                 vid_q_valid,
    input  logic                 srch_rd_en,
    input  logic [SW-1:0]        srch_slot_a,
    input  logic [SW-1:0]        srch_slot_b,
    input  logic [AW-1:0]        srch_add_a,
    input  logic [AW-1:0]        srch_add_b,
    output logic [2*ROW_W-1:0]   srch_q,
    output logic                 srch_q_valid
`ifdef FP_STORE_CSUM_EN
    ,
    output logic [15:0]          wr_csum,
    output logic                 wr_csum_valid
`endif
);

    // Address space is {slot,add}; sized to the full index range so a
    // non-power-of-two DEPTH or N_SLOTS never indexes past the array.
    localparam int unsigned MEM_ROWS = 1 << (SW + AW);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_COMMIT, S_DRAIN} state_e;

    state_e               state_q;
    logic [SW-1:0]        slot_q;
    logic [AW-1:0]        cnt_q;
    logic                 wr_ready_q;
    logic                 wr_busy_q;
    logic                 wr_err_q;
    logic [N_SLOTS-1:0]   slot_valid_q;

    logic [ROW_W-1:0]     mem [MEM_ROWS];
    logic                 mem_we;
    logic [SW+AW-1:0]     mem_waddr;

    logic [ROW_W-1:0]     vid_q_q;
    logic                 vid_q_valid_q;
    logic [2*ROW_W-1:0]   srch_q_q;
    logic                 srch_q_valid_q;

    logic                 accept;
    logic                 vid_ok;
    logic                 srch_ok;

    assign accept = wr_valid && wr_ready_q;

    // A slot is readable when committed and not the slot the writer owns.
    assign vid_ok  = vid_rd_en && slot_valid_q[vid_slot]
                     && !(wr_busy_q && (vid_slot == slot_q));
    assign srch_ok = srch_rd_en
                     && slot_valid_q[srch_slot_a] && !(wr_busy_q && (srch_slot_a == slot_q))
                     && slot_valid_q[srch_slot_b] && !(wr_busy_q && (srch_slot_b == slot_q));

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = {slot_q, cnt_q};
        if (accept) begin
            if ((state_q == S_IDLE) && wr_first) begin
                mem_we    = 1'b1;
                mem_waddr = {wr_slot, {AW{1'b0}}};
            end else if (state_q == S_WRITE) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            slot_q       <= '0;
            cnt_q        <= '0;
            wr_ready_q   <= 1'b1;
            wr_busy_q    <= 1'b0;
            wr_err_q     <= 1'b0;
            slot_valid_q <= '0;
        end else begin
            wr_err_q <= 1'b0;
            // Clear is listed before the FSM so a commit of another slot in the
            // same cycle still lands; a clear of the owned slot is ignored.
            if (clr_en && !(wr_busy_q && (clr_slot == slot_q))) begin
                slot_valid_q[clr_slot] <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept && wr_first) begin
                        slot_q                <= wr_slot;
                        slot_valid_q[wr_slot] <= 1'b0;
                        cnt_q                 <= AW'(1);
                        if (DEPTH == 1) begin
                            wr_busy_q <= 1'b1;
                            if (wr_last) begin
                                state_q    <= S_COMMIT;
                                wr_ready_q <= 1'b0;
                            end else begin
                                wr_err_q <= 1'b1;
                                state_q  <= S_DRAIN;
                            end
                        end else if (wr_last) begin
                            wr_err_q <= 1'b1;
                        end else begin
                            state_q   <= S_WRITE;
                            wr_busy_q <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (accept) begin
                        cnt_q <= cnt_q + AW'(1);
                        if (cnt_q == AW'(DEPTH - 1)) begin
                            if (wr_last) begin
                                state_q    <= S_COMMIT;
                                wr_ready_q <= 1'b0;
                            end else begin
                                wr_err_q <= 1'b1;
                                state_q  <= S_DRAIN;
                            end
                        end else if (wr_last) begin
                            wr_err_q  <= 1'b1;
                            state_q   <= S_IDLE;
                            wr_busy_q <= 1'b0;
                        end
                    end
                end
                S_COMMIT: begin
                    slot_valid_q[slot_q] <= 1'b1;
                    state_q              <= S_IDLE;
                    wr_ready_q           <= 1'b1;
                    wr_busy_q            <= 1'b0;
                end
                S_DRAIN: begin
                    if (accept && wr_last) begin
                        state_q   <= S_IDLE;
                        wr_busy_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vid_q_q        <= '0;
            vid_q_valid_q  <= 1'b0;
            srch_q_q       <= '0;
            srch_q_valid_q <= 1'b0;
        end else begin
            vid_q_valid_q  <= vid_ok;
            vid_q_q        <= vid_ok ? mem[{vid_slot, vid_add}] : '0;
            srch_q_valid_q <= srch_ok;
            srch_q_q       <= srch_ok ? {mem[{srch_slot_b, srch_add_b}],
                                         mem[{srch_slot_a, srch_add_a}]} : '0;
        end
    end

    assign wr_ready     = wr_ready_q;
    assign wr_busy      = wr_busy_q;
    assign wr_err       = wr_err_q;
    assign slot_valid   = slot_valid_q;
    assign vid_q        = vid_q_q;
    assign vid_q_valid  = vid_q_valid_q;
    assign srch_q       = srch_q_q;
    assign srch_q_valid = srch_q_valid_q;

`ifdef FP_STORE_CSUM_EN
    function automatic logic [15:0] fold16(input logic [ROW_W-1:0] row);
        logic [15:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < ROW_W / 16; i++) begin
            acc ^= row[i*16 +: 16];
        end
        return acc;
    endfunction

    logic [15:0] csum_q;
    logic        csum_valid_q;

    // csum_q is stable during the pulse: nothing is accepted in COMMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q       <= '0;
            csum_valid_q <= 1'b0;
        end else begin
            csum_valid_q <= (state_q == S_COMMIT);
            if (accept) begin
                if ((state_q == S_IDLE) && wr_first) begin
                    csum_q <= fold16(wr_data);
                end else if (state_q == S_WRITE) begin
                    csum_q <= csum_q ^ fold16(wr_data);
                end
            end
        end
    end

    assign wr_csum       = csum_q;
    assign wr_csum_valid = csum_valid_q;
`endif

endmodule

// File: tb/tb_fp_template_store.sv
// Testbench for fp_template_store: per-cycle reference model of the store
// (row arrays, committed flags, template framing) feeding a scoreboard queue;
// a monitor on the falling edge pops and compares every output.
module tb_fp_template_store;

    localparam int unsigned ROW_W   = 256;
    localparam int unsigned DEPTH   = 256;
    localparam int unsigned N_SLOTS = 4;
    localparam int unsigned AW      = 8;
    localparam int unsigned SW      = 2;
    localparam int unsigned NCH     = ROW_W / 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 wr_valid = 1'b0, wr_first = 1'b0, wr_last = 1'b0;
    logic [SW-1:0]        wr_slot = '0;
    logic [ROW_W-1:0]     wr_data = '0;
    logic                 wr_ready, wr_busy, wr_err;
    logic                 clr_en = 1'b0;
    logic [SW-1:0]        clr_slot = '0;
    logic [N_SLOTS-1:0]   slot_valid;
    logic                 vid_rd_en = 1'b0;
    logic [SW-1:0]        vid_slot = '0;
    logic [AW-1:0]        vid_add = '0;
    logic [ROW_W-1:0]     vid_q;
    logic                 vid_q_valid;
    logic                 srch_rd_en = 1'b0;
    logic [SW-1:0]        srch_slot_a = '0, srch_slot_b = '0;
    logic [AW-1:0]        srch_add_a = '0, srch_add_b = '0;
    logic [2*ROW_W-1:0]   srch_q;
    logic                 srch_q_valid;
`ifdef FP_STORE_CSUM_EN
    logic [15:0]          wr_csum;
    logic                 wr_csum_valid;
`endif

    fp_template_store #(.ROW_W(ROW_W), .DEPTH(DEPTH), .N_SLOTS(N_SLOTS)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_first(wr_first), .wr_last(wr_last),
        .wr_slot(wr_slot), .wr_data(wr_data), .wr_busy(wr_busy), .wr_err(wr_err),
        .clr_en(clr_en), .clr_slot(clr_slot), .slot_valid(slot_valid),
        .vid_rd_en(vid_rd_en), .vid_slot(vid_slot), .vid_add(vid_add),
        .vid_q(vid_q), .vid_q_valid(vid_q_valid),
        .srch_rd_en(srch_rd_en), .srch_slot_a(srch_slot_a), .srch_slot_b(srch_slot_b),
        .srch_add_a(srch_add_a), .srch_add_b(srch_add_b),
        .srch_q(srch_q), .srch_q_valid(srch_q_valid)
`ifdef FP_STORE_CSUM_EN
        ,
        .wr_csum(wr_csum), .wr_csum_valid(wr_csum_valid)
`endif
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint               due;
        logic                 vv;
        logic [ROW_W-1:0]     vq;
        logic                 sv;
        logic [2*ROW_W-1:0]   sq;
        logic [N_SLOTS-1:0]   valid;
        logic                 err;
        logic                 busy;
        logic                 ready;
        logic                 cv;
        logic [15:0]          cs;
    } exp_t;

    exp_t sbq[$];
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    // Reference model: stored rows, committed flags, and where the writer is
    // within the current template.
    logic [ROW_W-1:0] rmem [N_SLOTS][DEPTH];
    bit [N_SLOTS-1:0] rvalid;
    bit               m_writing, m_drain, m_commit;
    int               m_slot, m_rows;

    function automatic void chk(string name, logic [2*ROW_W-1:0] act, logic [2*ROW_W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic logic [15:0] tpl_csum(int s);
        logic [15:0] c;
        c = '0;
        for (int r = 0; r < DEPTH; r++)
            for (int k = 0; k < NCH; k++)
                c ^= rmem[s][r][k*16 +: 16];
        return c;
    endfunction

    function automatic logic [ROW_W-1:0] row_of(int kind, int i);
        logic [ROW_W-1:0] r;
        logic [15:0] v;
        v = 16'(i);
        r = '1;
        if (kind == 0) begin
            for (int k = 0; k < NCH; k++) r[k*16 +: 16] = v;
        end else if (kind == 1) begin
            for (int k = 0; k < ROW_W / 32; k++) r[k*32 +: 32] = $urandom;
        end
        return r;
    endfunction

    // Monitor: compares whatever is due this cycle.
    always @(negedge clk) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            chk("vid_q_valid", vid_q_valid, e.vv);
            chk("vid_q", vid_q, e.vq);
            chk("srch_q_valid", srch_q_valid, e.sv);
            chk("srch_q", srch_q, e.sq);
            chk("slot_valid", slot_valid, e.valid);
            chk("wr_err", wr_err, e.err);
            chk("wr_busy", wr_busy, e.busy);
            chk("wr_ready", wr_ready, e.ready);
`ifdef FP_STORE_CSUM_EN
            chk("wr_csum_valid", wr_csum_valid, e.cv);
            if (e.cv) chk("wr_csum", wr_csum, e.cs);
`endif
        end
    end

    task automatic idle_in();
        wr_valid = 0; wr_first = 0; wr_last = 0;
        clr_en = 0; vid_rd_en = 0; srch_rd_en = 0;
    endtask

    // Predict the response to the inputs currently applied, advance the model
    // and the clock by one cycle.
    task automatic step();
        exp_t e;
        bit busy0, a_ok, b_ok, acc, err;
        logic [N_SLOTS-1:0] nv;
        busy0 = m_writing || m_drain || m_commit;
        e.due = cyc + 1;
        e.vv = vid_rd_en && rvalid[vid_slot] && !(busy0 && int'(vid_slot) == m_slot);
        e.vq = e.vv ? rmem[vid_slot][vid_add] : '0;
        a_ok = rvalid[srch_slot_a] && !(busy0 && int'(srch_slot_a) == m_slot);
        b_ok = rvalid[srch_slot_b] && !(busy0 && int'(srch_slot_b) == m_slot);
        e.sv = srch_rd_en && a_ok && b_ok;
        e.sq = e.sv ? {rmem[srch_slot_b][srch_add_b], rmem[srch_slot_a][srch_add_a]} : '0;
        err = 0; e.cv = 0; e.cs = '0;
        nv = rvalid;
        acc = wr_valid && !m_commit;
        if (clr_en && !(busy0 && int'(clr_slot) == m_slot)) nv[clr_slot] = 1'b0;
        if (m_commit) begin
            nv[m_slot] = 1'b1;
            m_commit = 0;
            e.cv = 1;
            e.cs = tpl_csum(m_slot);
        end else if (acc) begin
            if (m_drain) begin
                if (wr_last) m_drain = 0;
            end else if (m_writing) begin
                rmem[m_slot][m_rows] = wr_data;
                if (m_rows == DEPTH - 1) begin
                    m_writing = 0;
                    if (wr_last) m_commit = 1;
                    else begin err = 1; m_drain = 1; end
                end else if (wr_last) begin
                    err = 1; m_writing = 0;
                end else begin
                    m_rows++;
                end
            end else if (wr_first) begin
                m_slot = int'(wr_slot);
                nv[wr_slot] = 1'b0;
                rmem[wr_slot][0] = wr_data;
                m_rows = 1;
                if (wr_last) err = 1;
                else m_writing = 1;
            end
        end
        rvalid = nv;
        e.valid = nv;
        e.err = err;
        e.busy = m_writing || m_drain || m_commit;
        e.ready = !m_commit;
        sbq.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        exp_t e;
        idle_in();
        sbq.delete();
        rst_n = 0;
        rvalid = '0; m_writing = 0; m_drain = 0; m_commit = 0; m_slot = 0; m_rows = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        e.due = cyc; e.vv = 0; e.vq = '0; e.sv = 0; e.sq = '0; e.valid = '0;
        e.err = 0; e.busy = 0; e.ready = 1; e.cv = 0; e.cs = '0;
        sbq.push_back(e);
    endtask

    task automatic rand_side();
        vid_rd_en = 1'($urandom); vid_slot = SW'($urandom); vid_add = AW'($urandom);
        srch_rd_en = 1'($urandom); srch_slot_a = SW'($urandom); srch_slot_b = SW'($urandom);
        srch_add_a = AW'($urandom); srch_add_b = AW'($urandom);
        clr_en = ($urandom_range(0, 15) == 0); clr_slot = SW'($urandom);
    endtask

    // side: 0 quiet, 1 random reads/clears, 2 fixed clear/read probes mid-write
    task automatic write_tpl(int slot, int nb, int last_at, int kind, int side);
        for (int i = 0; i < nb; i++) begin
            idle_in();
            wr_valid = 1; wr_first = (i == 0); wr_last = (i == last_at);
            wr_slot = SW'(slot); wr_data = row_of(kind, i);
            if (side == 1) rand_side();
            if (side == 2) begin
                if (i == 20) begin clr_en = 1; clr_slot = SW'(slot); end
                if (i == 40) begin clr_en = 1; clr_slot = 0; end
                if (i == 60) begin vid_rd_en = 1; vid_slot = SW'(slot); vid_add = 3; end
                if (i == 61) begin
                    srch_rd_en = 1; srch_slot_a = SW'(slot); srch_slot_b = 2;
                    srch_add_a = 1; srch_add_b = 1;
                end
            end
            step();
        end
        idle_in();
        step();
        step();
    endtask

    task automatic vid_read(int s, int a);
        idle_in(); vid_rd_en = 1; vid_slot = SW'(s); vid_add = AW'(a); step();
        idle_in(); step();
    endtask

    task automatic srch_read(int sa, int aa, int sb, int ab);
        idle_in(); srch_rd_en = 1; srch_slot_a = SW'(sa); srch_add_a = AW'(aa);
        srch_slot_b = SW'(sb); srch_add_b = AW'(ab); step();
        idle_in(); step();
    endtask

    task automatic clear(int s);
        idle_in(); clr_en = 1; clr_slot = SW'(s); step();
        idle_in(); step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, r;
        do_reset();
        step();
        // full template into slot 2, then read row 5
        write_tpl(2, DEPTH, DEPTH - 1, 0, 0);
        vid_read(2, 5);
        // early wr_last into slot 1
        write_tpl(1, 11, 10, 0, 0);
        vid_read(1, 3);
        // overrun past the last row, then drained beats
        write_tpl(0, DEPTH + 3, DEPTH + 2, 1, 0);
        vid_read(0, 4);
        // slots 0 and 3, paired search, then clear slot 3
        write_tpl(0, DEPTH, DEPTH - 1, 1, 0);
        write_tpl(3, DEPTH, DEPTH - 1, 1, 0);
        srch_read(0, 7, 3, 9);
        clear(3);
        srch_read(0, 7, 3, 9);
        // clears and reads while slot 1 is owned by the writer
        write_tpl(1, DEPTH, DEPTH - 1, 0, 2);
        srch_read(1, 200, 2, 100);
        // single-beat template is a framing error
        write_tpl(3, 1, 0, 1, 0);
        // all-ones template (checksum cancels for even DEPTH)
        write_tpl(2, DEPTH, DEPTH - 1, 2, 0);
        vid_read(2, DEPTH - 1);
        // reset in the middle of a write
        write_tpl(0, 50, -1, 1, 0);
        do_reset();
        for (int s = 0; s < N_SLOTS; s++) vid_read(s, 0);
        // randomized templates with concurrent reads and clears
        for (int t = 0; t < 8; t++) begin
            k = $urandom_range(0, 9);
            if (k < 7) write_tpl($urandom_range(0, N_SLOTS - 1), DEPTH, DEPTH - 1, 1, 1);
            else if (k == 7) begin
                r = $urandom_range(1, DEPTH - 2);
                write_tpl($urandom_range(0, N_SLOTS - 1), r + 1, r, 1, 1);
            end else if (k == 8) begin
                r = DEPTH + $urandom_range(1, 4);
                write_tpl($urandom_range(0, N_SLOTS - 1), r, r - 1, 1, 1);
            end else write_tpl($urandom_range(0, N_SLOTS - 1), 1, 0, 1, 1);
            for (int j = 0; j < 6; j++) begin
                idle_in(); rand_side(); step();
            end
        end
        for (int s = 0; s < N_SLOTS; s++) srch_read(s, $urandom_range(0, DEPTH - 1),
                                                      (s + 1) % N_SLOTS, $urandom_range(0, DEPTH - 1));
        idle_in();
        step();
        step();
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (sbq.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending entries, required 0", sbq.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fp_template_store.md
# fp_template_store

Multi-slot fingerprint template store replacing the fixed two-ROM arrangement. Holds `N_SLOTS` templates of `DEPTH` rows × `ROW_W` bits, written by the sensor/extract path through a framed valid/ready stream and read concurrently by the LCD video path (one row) and the matcher search path (two rows, probe and reference). Per-slot valid flags prevent display or matching of partially written or failed templates.

## Interface
- `ROW_W`, 256, row width in bits; must be a multiple of 16.
- `DEPTH`, 256, rows per template; `AW = clog2(DEPTH)` is a localparam.
- `N_SLOTS`, 4, template slots, ≥2; `SW = clog2(N_SLOTS)` is a localparam.

Ports:
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: asynchronous active-low reset.
- `wr_valid` in 1: write beat valid.
- `wr_ready` out 1: beat accepted when `wr_valid && wr_ready`.
- `wr_first` in 1: first beat of a template; meaningful in IDLE only.
- `wr_last` in 1: last beat of a template.
- `wr_slot` in SW: target slot, sampled with the `wr_first` beat.
- `wr_data` in ROW_W: row data.
- `wr_busy` out 1: FSM is not IDLE.
- `wr_err` out 1: one-cycle pulse on a framing error.
- `clr_en` in 1: invalidate slot `clr_slot`.
- `clr_slot` in SW.
- `slot_valid` out N_SLOTS: per-slot committed flag.
- `vid_rd_en` in 1, `vid_slot` in SW, `vid_add` in AW: video read request.
- `vid_q` out ROW_W, `vid_q_valid` out 1: video read result.
- `srch_rd_en` in 1, `srch_slot_a`/`srch_slot_b` in SW, `srch_add_a`/`srch_add_b` in AW: search read request.
- `srch_q` out 2*ROW_W, `srch_q_valid` out 1: `{row_b, row_a}`.

## Operation
- FSM states: IDLE, WRITE, COMMIT, DRAIN.
- IDLE: `wr_ready`=1. An accepted beat with `wr_first` latches the slot, clears `slot_valid[slot]`, writes row 0, sets the row counter to 1, and enters WRITE. A single-beat template (`wr_first && wr_last`) with DEPTH>1 is an error and goes to IDLE with `wr_err`. Beats without `wr_first` are accepted and dropped.
- WRITE: `wr_ready`=1; each accepted beat writes row `cnt` then increments `cnt`. `wr_first` is ignored.
  - Beat at row DEPTH-1 with `wr_last`: go to COMMIT.
  - `wr_last` on a row below DEPTH-1: `wr_err`, slot stays invalid, go to IDLE.
  - Beat at row DEPTH-1 without `wr_last`: `wr_err`, go to DRAIN.
- COMMIT: `wr_ready`=0 for one cycle. Sets `slot_valid[slot]`, then IDLE.
- DRAIN: `wr_ready`=1; beats are dropped until an accepted `wr_last`, then IDLE.
- Clear: `clr_en` clears `slot_valid[clr_slot]` next cycle. It is ignored when `clr_slot` equals the slot in WRITE/COMMIT/DRAIN. A commit and a clear of different slots in the same cycle both take effect.
- Reads return forced zero with `*_q_valid`=0 when any addressed slot is invalid or is the active write slot. `srch_q_valid` requires both slot a and slot b to qualify.
- Memory: `N_SLOTS*DEPTH` rows, flat address `{slot,add}`; contents are not reset.

## Timing
- Read latency is 1 cycle: request at cycle n, `vid_q`/`srch_q` and the valid flags registered at n+1. Validity is evaluated at n.
- A write at cycle n is visible to a read issued at n+1 or later.
- A write to COMMIT completes in DEPTH accepted beats + 1 cycle; `slot_valid` rises the cycle after COMMIT.
- `wr_err` is a one-cycle pulse registered the cycle after the offending beat.
- Reset values: `slot_valid`=0, `wr_ready`=1, `wr_busy`=0, `wr_err`=0, `vid_q`=0, `srch_q`=0, both valid flags 0, FSM=IDLE, `cnt`=0.
- Reset mid-write aborts the write; all slots are invalid afterwards.

## Configuration
- `FP_STORE_CSUM_EN` defined:
  - Adds outputs `wr_csum` [15:0] and `wr_csum_valid` [1].
  - `wr_csum` is the XOR of every 16-bit chunk of every written row of the template. It resets to 0 on `wr_first`.
  - `wr_csum` is presented with a one-cycle `wr_csum_valid` pulse in the same cycle `slot_valid` rises. There is no pulse on error.
- Not defined: the ports and logic are absent; all other behaviour is identical.

## Test plan
- Reset, then write slot 2 with DEPTH rows, row i = {ROW_W/16{i[15:0]}} -> `slot_valid`=4'b0100 after COMMIT; `vid_slot`=2, `vid_add`=5 -> next cycle `vid_q` = {16{16'h0005}}, `vid_q_valid`=1.
- `wr_last` at row 10 into slot 1 -> `wr_err` pulse, `slot_valid[1]`=0; a read of slot 1 returns 0 with valid 0.
- Row DEPTH-1 without `wr_last`, then 3 extra beats with `wr_last` on the third -> one `wr_err`, beats dropped, FSM IDLE, slot invalid.
- Slots 0 and 3 committed; `srch_slot_a`=0, `srch_add_a`=7, `srch_slot_b`=3, `srch_add_b`=9 -> `srch_q` = {slot3 row9, slot0 row7}, valid 1. `clr_en` on slot 3 -> the next search gives valid 0, data 0.
- While slot 1 is being written, `clr_en` on slot 1 is ignored and `clr_en` on slot 0 clears slot 0. A read of slot 1 during the write returns valid 0.
- With `FP_STORE_CSUM_EN` and all rows = all-ones, DEPTH=256 -> `wr_csum`=16'h0000. With DEPTH odd -> 16'hFFFF if ROW_W/16 is odd.
